// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the IF-stage next-PC generator: group geometry,
// checkpoint width, reset vector and the delay-slot tracking states.
package fetch_pc_gen_pkg;

    localparam int          SINGLE_WORD  = 32;           // one instruction word
    localparam int          SLOTS        = 4;            // words per fetch group
    localparam int          GHT_CKPT_W   = 36;           // dest[31:2], ghr, counter
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;

    // NORMAL: free to follow predictions. WAIT_DS: the previous group ended
    // on a taken branch in slot 3, so this group only carries its delay slot.
    typedef enum logic {
        NORMAL  = 1'b0,
        WAIT_DS = 1'b1
    } fetch_state_e;

    // Address of the next sequential fetch group (wraps silently at the top).
    function automatic logic [SINGLE_WORD-1:0] next_group(input logic [SINGLE_WORD-1:0] pc);
        return {pc[SINGLE_WORD-1:4] + 28'd1, 4'b0000};
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bus of the PC generator: request handshake, prediction lookup,
// backend redirect and the registered fetch-group descriptor.
interface fetch_pc_gen_if
    import fetch_pc_gen_pkg::*;
#(
    parameter int CKPT_W = GHT_CKPT_W
);
    logic                          inst_req_o;
    logic                          inst_index_ok_i;
    logic [SINGLE_WORD-1:0]        pcr_vaddr_o;
    logic [SLOTS-1:0]              pred_take_i;
    logic [SLOTS*SINGLE_WORD-1:0]  pred_dest_i;
    logic [SLOTS*CKPT_W-1:0]       pred_ckpt_i;
    logic                          redirect_i;
    logic [SINGLE_WORD-1:0]        redirect_vaddr_i;
    logic                          grp_valid_o;
    logic [SINGLE_WORD-1:0]        grp_vaddr_o;
    logic [SLOTS-1:0]              grp_mask_o;
    logic                          grp_take_o;
    logic [1:0]                    grp_take_slot_o;
    logic [CKPT_W-1:0]             grp_ckpt_o;

    // PC generator side
    modport master (
        output inst_req_o, pcr_vaddr_o,
               grp_valid_o, grp_vaddr_o, grp_mask_o, grp_take_o, grp_take_slot_o, grp_ckpt_o,
        input  inst_index_ok_i, pred_take_i, pred_dest_i, pred_ckpt_i,
               redirect_i, redirect_vaddr_i
    );

    // Environment side (cache, predictors, backend, next IF stage)
    modport slave (
        input  inst_req_o, pcr_vaddr_o,
               grp_valid_o, grp_vaddr_o, grp_mask_o, grp_take_o, grp_take_slot_o, grp_ckpt_o,
        output inst_index_ok_i, pred_take_i, pred_dest_i, pred_ckpt_i,
               redirect_i, redirect_vaddr_i
    );
endinterface

// File: rtl/fetch_pc_gen_pred_slot_select.sv
// Combinational slot picker: from the group start slot, per-slot taken
// predictions and the delay-slot state, find the first predicted-taken
// valid slot and the mask of slots the group actually executes.
module fetch_pc_gen_pred_slot_select
    import fetch_pc_gen_pkg::*;
(
    input  logic [1:0]       start_slot_i,
    input  logic [SLOTS-1:0] take_i,
    input  logic             wait_ds_i,
    output logic [1:0]       slot_o,
    output logic             found_o,
    output logic [SLOTS-1:0] mask_o
);
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] hit;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            localparam logic [2:0] SLOT_IDX = 3'(gi);
            // Slots before the entry point are not part of this fetch; in
            // WAIT_DS only the delay slot itself is.
            assign valid[gi] = (SLOT_IDX >= {1'b0, start_slot_i}) &&
                               (!wait_ds_i || SLOT_IDX == {1'b0, start_slot_i});
            // Predictions are ignored while fetching a lone delay slot.
            assign hit[gi]   = valid[gi] && take_i[gi] && !wait_ds_i;
            // A taken branch keeps its delay slot (slot j+1) and drops the rest.
            assign mask_o[gi] = valid[gi] &&
                                (!found_o || SLOT_IDX <= ({1'b0, slot_o} + 3'd1));
        end
    endgenerate

    // Priority pick of the lowest hitting slot.
    always_comb begin
        found_o = 1'b0;
        slot_o  = 2'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found_o = 1'b1;
                slot_o  = 2'(i);
            end
        end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage next-PC generator: holds the PCR, issues the fetch request,
// follows branch predictions (tracking a slot-3 branch whose delay slot lies
// in the next group) and registers the accepted fetch-group descriptor.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CKPT_W   = GHT_CKPT_W
)(
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);
    fetch_state_e           state_q, state_d;
    logic [SINGLE_WORD-1:0] pcr_q, pcr_d;
    logic [SINGLE_WORD-1:0] pending_q, pending_d;
    logic                   req_en_q, req_en_d;
    logic                   grp_valid_q, grp_valid_d;
    logic [SINGLE_WORD-1:0] grp_vaddr_q, grp_vaddr_d;
    logic [SLOTS-1:0]       grp_mask_q, grp_mask_d;
    logic                   grp_take_q, grp_take_d;
    logic [1:0]             grp_slot_q, grp_slot_d;
    logic [CKPT_W-1:0]      grp_ckpt_q, grp_ckpt_d;

    logic [1:0]             sel_slot;
    logic                   sel_found;
    logic [SLOTS-1:0]       sel_mask;
    logic                   handshake;

    fetch_pc_gen_pred_slot_select u_sel (
        .start_slot_i (pcr_q[3:2]),
        .take_i       (bus.pred_take_i),
        .wait_ds_i    (state_q == WAIT_DS),
        .slot_o       (sel_slot),
        .found_o      (sel_found),
        .mask_o       (sel_mask)
    );

    // The request is suppressed for the first cycle out of reset and
    // whenever the backend is redirecting.
    assign bus.inst_req_o      = req_en_q && !rst && !bus.redirect_i;
    assign handshake           = bus.inst_req_o && bus.inst_index_ok_i;
    assign bus.pcr_vaddr_o     = pcr_q;
    assign bus.grp_valid_o     = grp_valid_q;
    assign bus.grp_vaddr_o     = grp_vaddr_q;
    assign bus.grp_mask_o      = grp_mask_q;
    assign bus.grp_take_o      = grp_take_q;
    assign bus.grp_take_slot_o = grp_slot_q;
    assign bus.grp_ckpt_o      = grp_ckpt_q;

    // Next-PC selection: redirect, stall, delay-slot group, taken branch, sequential.
    always_comb begin
        state_d     = state_q;
        pcr_d       = pcr_q;
        pending_d   = pending_q;
        req_en_d    = 1'b1;
        grp_valid_d = 1'b0;
        grp_vaddr_d = '0;
        grp_mask_d  = '0;
        grp_take_d  = 1'b0;
        grp_slot_d  = 2'd0;
        grp_ckpt_d  = '0;

        if (bus.redirect_i) begin
            pcr_d     = bus.redirect_vaddr_i;
            state_d   = NORMAL;
            pending_d = '0;
        end else if (handshake) begin
            grp_valid_d = 1'b1;
            grp_vaddr_d = pcr_q;
            grp_mask_d  = sel_mask;
            if (state_q == WAIT_DS) begin
                pcr_d     = pending_q;
                pending_d = '0;
                state_d   = NORMAL;
            end else if (sel_found) begin
                grp_take_d = 1'b1;
                grp_slot_d = sel_slot;
                grp_ckpt_d = bus.pred_ckpt_i[CKPT_W*int'(sel_slot) +: CKPT_W];
                if (sel_slot == 2'd3) begin
                    // Delay slot sits in the next group; park the target.
                    pcr_d     = next_group(pcr_q);
                    pending_d = bus.pred_dest_i[SINGLE_WORD*3 +: SINGLE_WORD];
                    state_d   = WAIT_DS;
                end else begin
                    pcr_d = bus.pred_dest_i[SINGLE_WORD*int'(sel_slot) +: SINGLE_WORD];
                end
            end else begin
                pcr_d = next_group(pcr_q);
            end
        end
    end

    // State, PCR and descriptor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NORMAL;
            pcr_q       <= RESET_PC;
            pending_q   <= '0;
            req_en_q    <= 1'b0;
            grp_valid_q <= 1'b0;
            grp_vaddr_q <= '0;
            grp_mask_q  <= '0;
            grp_take_q  <= 1'b0;
            grp_slot_q  <= 2'd0;
            grp_ckpt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pcr_q       <= pcr_d;
            pending_q   <= pending_d;
            req_en_q    <= req_en_d;
            grp_valid_q <= grp_valid_d;
            grp_vaddr_q <= grp_vaddr_d;
            grp_mask_q  <= grp_mask_d;
            grp_take_q  <= grp_take_d;
            grp_slot_q  <= grp_slot_d;
            grp_ckpt_q  <= grp_ckpt_d;
        end
    end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Next-PC generator and PCR register for the IF stage, directly upstream of the global history table and BTB.
- Drives the 4-word-aligned fetch VAddr that the history table and BTB look up.
- Consumes their per-slot predictions and picks the next PC.
- Issues the fetch request, tracking MIPS delay slots across fetch-group boundaries.
- Hands a registered fetch-group descriptor (valid mask, taken slot, checkpoint) to the next IF stage.

Parameters:
RESET_PC, 32'hBFC00000, PCR value after reset.
CKPT_W, 36, width of one history-table checkpoint (dest[31:2], ghr, counter).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
inst_req_o  output  1  fetch request for the group at pcr_vaddr_o
inst_index_ok_i  input  1  request accepted this cycle (handshake completes when inst_req_o && inst_index_ok_i)
pcr_vaddr_o  output  32  current fetch VAddr; drives history table and BTB lookup
pred_take_i  input  4  per-slot taken prediction (combinational from pcr_vaddr_o)
pred_dest_i  input  128  per-slot predicted target, slot i at [32i+31:32i]
pred_ckpt_i  input  4*CKPT_W  per-slot checkpoint
redirect_i  input  1  backend misprediction redirect
redirect_vaddr_i  input  32  correct target for redirect
grp_valid_o  output  1  registered descriptor valid (one cycle per accepted request)
grp_vaddr_o  output  32  VAddr of the accepted group
grp_mask_o  output  4  slots of the group to execute
grp_take_o  output  1  a taken branch was predicted in the group
grp_take_slot_o  output  2  slot of that branch
grp_ckpt_o  output  CKPT_W  checkpoint of that branch slot (zero if grp_take_o=0)

Behaviour:
- Reset (rst=1 at a clk edge), outputs after the edge:
  - pcr=RESET_PC; state=NORMAL; pending target cleared.
  - inst_req_o=0 for that cycle; grp_* all zero.
  - inst_req_o is 1 in every cycle with rst=0 and redirect_i=0.
- Start slot s = pcr[3:2]. Slots below s are invalid. In WAIT_DS only slot s is valid.
- Predicted branch: the lowest valid slot j with pred_take_i[j]=1. Ignored in WAIT_DS.
- Next-PC priority, applied at the clk edge:
  1. redirect_i: pcr<=redirect_vaddr_i; state<=NORMAL; pending cleared; grp_valid_o<=0. Takes effect even without a handshake; inst_req_o=0 in the redirect cycle.
  2. No handshake: pcr and state hold; grp_valid_o<=0.
  3. Handshake in WAIT_DS: pcr<=pending; state<=NORMAL; mask=one-hot(s); grp_take_o=0.
  4. Handshake, NORMAL, j exists, j<3: pcr<=pred_dest_i[j]; mask = valid slots s..j+1 (delay slot included); grp_take_slot_o=j; grp_ckpt_o=ckpt[j].
  5. Handshake, NORMAL, j==3: pcr<={pcr[31:4]+1,4'b0}; pending<=pred_dest_i[3]; state<=WAIT_DS; mask=valid slots s..3; take slot 3.
  6. Handshake, NORMAL, no j: pcr<={pcr[31:4]+1,4'b0}; mask=valid slots s..3; grp_take_o=0.
- pcr wraps silently at 32'hFFFFFFF0 + 16 → 0.
- grp_* latency: registered one cycle after the handshake edge. Cleared on rst or redirect_i in the same edge.
- Redirect during WAIT_DS or during a stalled request cancels the pending target; no group is emitted.

Decomposition:
- Shared defines header: SINGLE_WORD, GHT_CHECKPOINT width, RESET_PC, state encodings NORMAL / WAIT_DS.
- Sub-module pred_slot_select (combinational): start slot + take vector + WAIT_DS → j, found, mask. Independently unit-testable.

Test Plan:
- Reset release, no predictions, ok=1 every cycle → pcr BFC00000, BFC00010, BFC00020; masks 1111 each.
- pcr=0x1008, take=0100, dest[2]=0x2000 → next pcr 0x2000; mask 1100; take_slot 2; ckpt = ckpt[2].
- pcr=0x1000, take=1000, dest[3]=0x3004 → pcr 0x1010 in WAIT_DS, mask 0001 with take=0; then pcr 0x3004, mask starts at slot 1.
- pcr=0x100C, take=1001 (slot 0 ignored) → slot 3 chosen, WAIT_DS entered.
- WAIT_DS with ok=0 for 3 cycles, then redirect_i=1 to 0x5000 → pcr 0x5000, NORMAL, no group emitted, pending dropped.
- rst asserted while WAIT_DS with ok=1 → pcr BFC00000, grp_valid_o=0, inst_req_o=0 next cycle.
